// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package rr_mux4_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot encode a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after ptr, modulo 4.
module rr_pick4
  import rr_mux4_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  logic [SEL_W-1:0] w_cand;

  // Scan from the farthest position back to ptr so the closest hit is written last.
  always_comb begin
    idx    = ptr;
    valid  = 1'b0;
    w_cand = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = ptr + SEL_W'(k);
      if (req[w_cand]) begin
        idx   = w_cand;
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving select/enable of a shared 4:1 single-bit path.
// Each tenure is bounded to HOLD_MAX cycles; handover is back-to-back.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] D,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] s,
  output logic             en,
  output logic             y
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic [SEL_W-1:0] r_s;
  logic             r_en;

  logic [SEL_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [SEL_W-1:0] w_s_nxt;
  logic             w_en_nxt;

  logic             w_release;
  logic [SEL_W-1:0] w_pick_ptr;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_pick_valid;

  // The current holder releases when it drops its request or its tenure is used up.
  assign w_release  = (r_state == GRANT) && (!req[r_s] || (r_cnt == HOLD_LIM));
  // In GRANT the only pick that matters is the release pick, which starts after the holder.
  assign w_pick_ptr = (r_state == GRANT) ? (r_s + 2'd1) : r_ptr;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  // State and registered outputs; reset abandons any tenure without release bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= 4'd0;
      r_grant <= 4'b0000;
      r_s     <= 2'd0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_s     <= w_s_nxt;
      r_en    <= w_en_nxt;
    end
  end

  // Next-state: enter/stay in GRANT whenever a valid pick exists at a decision point.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = GRANT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (w_release && !w_pick_valid) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GRANT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next output/counter/pointer values; s holds its last value whenever nothing is granted.
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_s_nxt     = r_s;
    w_en_nxt    = r_en;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_nxt = onehot(w_pick_idx);
          w_s_nxt     = w_pick_idx;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = 4'd1;
        end else begin
          w_grant_nxt = 4'b0000;
          w_en_nxt    = 1'b0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt = r_s + 2'd1;
          if (w_pick_valid) begin
            w_grant_nxt = onehot(w_pick_idx);
            w_s_nxt     = w_pick_idx;
            w_en_nxt    = 1'b1;
            w_cnt_nxt   = 4'd1;
          end else begin
            w_grant_nxt = 4'b0000;
            w_en_nxt    = 1'b0;
            w_cnt_nxt   = 4'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_grant_nxt = 4'b0000;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  // Shared datapath: zero-latency mux from D, forced low when no grant is active.
  always_comb begin
    if (r_en) begin
      y = D[r_s];
    end else begin
      y = 1'b0;
    end
  end

  assign grant = r_grant;
  assign s     = r_s;
  assign en    = r_en;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed self-checking bench for rr_mux4_arbiter (instances with HOLD_MAX 4 and 2).
module tb_rr_mux4_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] D;

  logic [3:0] ga, gb;
  logic [1:0] sa, sb;
  logic       ena, enb, ya, yb;

  int n_err;
  int n_chk;

  rr_mux4_arbiter #(.HOLD_MAX(4)) u_a (
    .clk(clk), .rst(rst), .req(req), .D(D),
    .grant(ga), .s(sa), .en(ena), .y(ya)
  );

  rr_mux4_arbiter #(.HOLD_MAX(2)) u_b (
    .clk(clk), .rst(rst), .req(req), .D(D),
    .grant(gb), .s(sb), .en(enb), .y(yb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    int rot_s [10];
    logic [3:0] eg;
    rot_s = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    n_err = 0;
    n_chk = 0;

    // Reset held two cycles with all requests up
    rst = 1'b1; req = 4'b1111; D = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_grant", ga, 4'b0000);
      chk("rst_en", {3'b000, ena}, 4'b0000);
      chk("rst_y", {3'b000, ya}, 4'b0000);
    end
    rst = 1'b0;
    tick();
    chk("first_grant", ga, 4'b0001);
    chk("first_s", {2'b00, sa}, 4'b0000);
    chk("first_y", {3'b000, ya}, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold0_grant", ga, 4'b0001);
    end
    tick();
    chk("tenure_bound_handover", ga, 4'b0010);

    // Round-robin rotation on HOLD_MAX=2 instance
    rst = 1'b1; req = 4'b1111;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      eg = 4'b0001 << rot_s[i];
      chk("rot_s", {2'b00, sb}, 4'(rot_s[i]));
      chk("rot_grant", gb, eg);
    end

    // Sole requester: continuous re-grant, no idle cycle
    rst = 1'b1; req = 4'b0100; D = 4'b0100;
    tick();
    rst = 1'b0;
    tick();
    chk("single_grant", ga, 4'b0100);
    chk("single_s", {2'b00, sa}, 4'b0010);
    chk("single_y", {3'b000, ya}, 4'b0001);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("single_regrant", ga, 4'b0100);
      chk("single_en", {3'b000, ena}, 4'b0001);
    end
    D = 4'b0000;
    #1;
    chk("y_follows_D_low", {3'b000, ya}, 4'b0000);
    D = 4'b0100;
    #1;
    chk("y_follows_D_high", {3'b000, ya}, 4'b0001);

    // Early release: pick after holder 1 starts at 2, so 3 beats 0
    rst = 1'b1; req = 4'b0010;
    tick();
    rst = 1'b0;
    tick();
    chk("early_grant1", ga, 4'b0010);
    req = 4'b1001; D = 4'b1000;
    tick();
    chk("early_handover", ga, 4'b1000);
    chk("early_s", {2'b00, sa}, 4'b0011);
    chk("early_y", {3'b000, ya}, 4'b0001);

    // Return to idle: s holds the last holder
    req = 4'b0000;
    tick();
    chk("idle_grant", ga, 4'b0000);
    chk("idle_en", {3'b000, ena}, 4'b0000);
    chk("idle_y", {3'b000, ya}, 4'b0000);
    chk("idle_s_hold", {2'b00, sa}, 4'b0011);

    // Move ptr to 2, start a tenure, then reset at cnt=3
    req = 4'b0010;
    tick();
    chk("pre_grant1", ga, 4'b0010);
    req = 4'b0000;
    tick();
    chk("pre_idle", {3'b000, ena}, 4'b0000);
    req = 4'b0110;
    tick();
    chk("ptr2_pick", ga, 4'b0100);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_grant", ga, 4'b0000);
    chk("midrst_en", {3'b000, ena}, 4'b0000);
    chk("midrst_s", {2'b00, sa}, 4'b0000);
    chk("midrst_y", {3'b000, ya}, 4'b0000);
    rst = 1'b0; req = 4'b1111;
    tick();
    chk("midrst_restart", ga, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin arbiter that shares one 4:1 single-bit selection datapath among four requesters. Each requester raises `req[i]` and presents its data bit on `D[i]`. The block grants one requester at a time, drives the select and enable for the shared path, and bounds each tenure to `HOLD_MAX` cycles. It sits directly in front of the 4:1 select path and replaces static `s`/`en` tie-offs.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive grant cycles per tenure; legal range 1..15.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: request per requester; level-sensitive and sampled every cycle.
- `D` in 4: data bit per requester.
- `grant` out 4: one-hot grant, or all-zero when idle.
- `s` out 2: index of the granted requester.
- `en` out 1: high while a grant is active.
- `y` out 1: shared output. Equals `D[s]` when `en` = 1, else 0.

## Operation
- **State machine:** two states, IDLE and GRANT. Internal state:
  - `ptr[1:0]`: round-robin start index.
  - `cnt[3:0]`: tenure length.
- **Pick function:**
  - Searches `req` from index `ptr` upward, modulo 4.
  - Returns the first asserted index and a valid flag.
  - The valid flag is 0 when `req` = 0.
- **IDLE:**
  - Outputs: `grant` = 0, `en` = 0, `s` holds its last value.
  - If the pick is valid, the next state is GRANT with `grant` = onehot(idx), `s` = idx, `en` = 1, `cnt` = 1.
- **GRANT:**
  - Release occurs when `req[s]` = 0 or `cnt` = `HOLD_MAX`.
  - Without release: `cnt` increments, and `grant`, `s` and `en` stay unchanged.
  - On release, `ptr` becomes `s`+1 (mod 4) and the pick reruns with that new `ptr`:
    - If the pick is valid: back-to-back handover with no idle cycle; new `grant`/`s`, `cnt` = 1.
    - If not valid: go to IDLE with `grant` = 0 and `en` = 0.
- **Sole requester:** a requester that is the only one asserting is re-granted immediately after its hold expires, with `cnt` reset to 1. It is searched last, so it gets no extra priority.
- **Grant invariant:** `grant` is always one-hot or zero, and `grant[s]` = `en`.
- **Requests during a tenure:** requests arriving mid-tenure never pre-empt it. They only affect the next pick.
- **`y` datapath:** combinational mux from `D` using the registered `s`/`en`. There is no x-propagation; it outputs 0 when disabled.
- **Counter width:** `cnt` saturates in practice because `HOLD_MAX` ≤ 15, and it never wraps.

## Timing
- **Reset values:** `grant` = 0, `s` = 0, `en` = 0, `y` = 0, `ptr` = 0, `cnt` = 0, state IDLE.
- **Reset mid-tenure:** reset during GRANT drops `grant`/`en` at the next edge. No release bookkeeping takes place; `ptr` returns to 0.
- **Grant latency:** `req` asserted before edge k gives `grant`/`en` visible after edge k, a 1-cycle latency.
- **Release latency:**
  - `req[s]` deasserted before edge k: `grant` moves or drops after edge k.
  - The requester therefore sees at most one extra granted cycle after it drops `req`.
- **Tenure bound:** at most `HOLD_MAX` cycles per tenure when other requesters are waiting.
- **Starvation bound:** worst-case wait for any asserted requester is 3·`HOLD_MAX` + 1 cycles.
- **Register boundaries:**
  - `grant`, `s` and `en` are registered.
  - `y` is combinational from `D` and the registered select. It has zero latency from `D`.
- **Simultaneous events:** release and a new `req` at the same edge are both honoured. The new request participates in that edge's pick.

## Structure
- **Shared package:**
  - State typedef `{IDLE, GRANT}`.
  - Constants `N_REQ` = 4 and `SEL_W` = 2.
  - `CNT_W` = 4.
- **Sub-module `rr_pick4`:** purely combinational.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `idx[1:0]`, `valid`.
  - Instantiated once, with its `ptr` input muxed between the stored `ptr` (IDLE) and `s`+1 (release).
- **Top level:** FSM, counter and the output mux stay in the top.

## Test plan
- **Reset values:** assert `rst` for 2 cycles with `req` = 4'b1111 → `grant` = 0, `en` = 0, `y` = 0 throughout; first grant after release is `grant` = 4'b0001, `s` = 0.
- **Single requester:** `req` = 4'b0100 held, `D` = 4'b0100, `HOLD_MAX` = 4 → grant 1 cycle after request; `s` = 2, `y` = 1; re-granted continuously with `cnt` wrapping 4→1 and no idle cycle.
- **Round-robin rotation:** `req` = 4'b1111 held, `HOLD_MAX` = 2 → grant sequence 0,0,1,1,2,2,3,3,0… with no gaps.
- **Early release:** grant to 1; drop `req[1]` after 1 cycle with `req[3]` pending → `grant` goes 4'b0010 → 4'b1000 at the next edge; `ptr` = 2 is observed via the next pick order.
- **Return to idle:** sole requester drops `req` → `en` = 0, `grant` = 0, `y` = 0 next cycle; `s` holds its value.
- **Reset mid-tenure:** `rst` asserted during GRANT with `cnt` = 3 → all outputs reach their reset values after one edge; after release, arbitration restarts from index 0.
